// File: rtl/sw_debounce_pulse.sv
// sw_debounce_pulse
//   Conditions a raw slide-switch / pushbutton input for the 7-segment counter
//   path. The input is synchronised and then debounced, and the module emits
//   one-cycle strobes on each debounced press and release. When REPEAT_EN=1,
//   holding the switch also produces auto-repeat press strobes: the first one
//   REPEAT_DELAY cycles after the press strobe, then one every REPEAT_PERIOD
//   cycles.
//
// Ports
//   clk           system clock, all logic on the rising edge
//   rst           synchronous, active-high reset
//   sw_in         raw switch level, asynchronous to clk
//   sw_level      debounced, synchronised switch level
//   press_pulse   one-cycle strobe on debounced press and on each auto-repeat
//   release_pulse one-cycle strobe on debounced release
//
// Repeat FSM
//   state  | meaning
//   IDLE   | switch released, waiting for a debounced rise
//   HOLD   | pressed, counting down REPEAT_DELAY to the first repeat
//   REPEAT | pressed, counting down REPEAT_PERIOD between repeats
module sw_debounce_pulse #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic sw_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW      = $clog2(TMR_MAX + 1);

  localparam logic [CW-1:0] CNT_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LOAD   = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LOAD  = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic [TW-1:0]          timer_q, timer_d;
  state_t                 state_q, state_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;

  logic sync_out;
  logic rise;
  logic fall;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sw_in};

    // Debounce: count consecutive disagreeing samples; any agreeing sample
    // restarts qualification.
    level_d = level_q;
    cnt_d   = '0;
    rise    = 1'b0;
    fall    = 1'b0;
    if (sync_out != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        rise    = ~level_q;
        fall    = level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // The repeat timer counts down to a terminal count of zero. Loading
    // N-1 on a strobe places the next strobe exactly N edges later.
    state_d   = state_q;
    timer_d   = timer_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (fall) begin
      // Release takes priority over a repeat expiring on the same edge.
      release_d = 1'b1;
      state_d   = IDLE;
      timer_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            press_d = 1'b1;
            state_d = HOLD;
            timer_d = DELAY_LOAD;
          end
        end
        HOLD: begin
          if (REPEAT_EN != 0) begin
            if (timer_q == '0) begin
              press_d = 1'b1;
              state_d = REPEAT;
              timer_d = PERIOD_LOAD;
            end else begin
              timer_d = timer_q - TW'(1);
            end
          end
        end
        REPEAT: begin
          if (timer_q == '0) begin
            press_d = 1'b1;
            timer_d = PERIOD_LOAD;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      timer_q   <= '0;
      state_q   <= IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      timer_q   <= timer_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign sw_level      = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_sw_debounce_pulse.sv
module tb_sw_debounce_pulse;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int DLY  = 10;
  localparam int PER  = 3;
  localparam int HN   = SYNC + DEB;

  logic clk = 1'b0;
  logic rst;
  logic sw_in;
  logic lvl_n, prs_n, rel_n;
  logic lvl_r, prs_r, rel_r;

  always #5 clk = ~clk;

  sw_debounce_pulse #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0),
    .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) u_norep (
    .clk(clk), .rst(rst), .sw_in(sw_in),
    .sw_level(lvl_n), .press_pulse(prs_n), .release_pulse(rel_n)
  );

  sw_debounce_pulse #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
    .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) u_rep (
    .clk(clk), .rst(rst), .sw_in(sw_in),
    .sw_level(lvl_r), .press_pulse(prs_r), .release_pulse(rel_r)
  );

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  int base     = 0;

  // Reference model: m_hist[k] is the sw_in value sampled k edges ago.
  // The level flips when every sample that has cleared the synchroniser in
  // the last DEB edges disagrees with it. Press strobes follow an absolute
  // edge schedule: rise edge P, then P+DLY, P+DLY+PER, ... while held.
  bit m_hist[HN];
  bit m_level;
  bit m_prs_n, m_prs_r, m_rel;
  int m_next;

  int prs_r_q[$];
  int prs_n_q[$];
  int rel_r_q[$];
  int rel_n_q[$];
  int seg_cnt;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_n, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input int got[$], input int exp[$]);
    chk_int({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk_int({tag, "_edge"}, got[i], exp[i]);
  endtask

  task automatic model_edge(input bit v, input bit r);
    bit flip;
    bit old_level;
    if (r) begin
      for (int i = 0; i < HN; i++) m_hist[i] = 1'b0;
      m_level = 1'b0;
      m_prs_n = 1'b0;
      m_prs_r = 1'b0;
      m_rel   = 1'b0;
      return;
    end
    for (int i = HN - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = v;
    flip = 1'b1;
    for (int i = SYNC; i < HN; i++)
      if (m_hist[i] == m_level) flip = 1'b0;
    old_level = m_level;
    if (flip) m_level = ~m_level;
    m_rel   = flip && old_level;
    m_prs_n = flip && !old_level;
    m_prs_r = 1'b0;
    if (flip && !old_level) begin
      m_prs_r = 1'b1;
      m_next  = edge_n + DLY;
    end else if (!flip && m_level && edge_n == m_next) begin
      m_prs_r = 1'b1;
      m_next  = edge_n + PER;
    end
  endtask

  task automatic tick(input bit v, input bit r);
    sw_in = v;
    rst   = r;
    @(posedge clk);
    edge_n++;
    model_edge(v, r);
    #1;
    chk("level_norep",   lvl_n, m_level);
    chk("press_norep",   prs_n, m_prs_n);
    chk("release_norep", rel_n, m_rel);
    chk("level_rep",     lvl_r, m_level);
    chk("press_rep",     prs_r, m_prs_r);
    chk("release_rep",   rel_r, m_rel);
    if (prs_r) prs_r_q.push_back(edge_n - base);
    if (prs_n) begin
      prs_n_q.push_back(edge_n - base);
      seg_cnt++;
    end
    if (rel_r) rel_r_q.push_back(edge_n - base);
    if (rel_n) rel_n_q.push_back(edge_n - base);
  endtask

  task automatic run(input bit v, input int n);
    repeat (n) tick(v, 1'b0);
  endtask

  task automatic start();
    base = edge_n;
    prs_r_q.delete();
    prs_n_q.delete();
    rel_r_q.delete();
    rel_n_q.delete();
  endtask

  initial begin
    int len;
    bit v;
    m_next  = -1;
    seg_cnt = 0;
    rst     = 1'b1;
    sw_in   = 1'b0;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    chk("reset_level", lvl_r, 1'b0);
    chk("reset_press", prs_r, 1'b0);
    chk("reset_release", rel_r, 1'b0);
    run(1'b0, 10);

    // Clean press without repeat
    start();
    run(1'b1, 20);
    chk_q("s1_press_norep", prs_n_q, '{6});
    start();
    run(1'b0, 10);
    chk_q("s1_release_norep", rel_n_q, '{6});
    chk_q("s1_press_after_fall", prs_n_q, '{});

    // Bounce rejection
    start();
    run(1'b1, 3); run(1'b0, 1);
    run(1'b1, 1); run(1'b0, 1);
    run(1'b1, 2); run(1'b0, 10);
    chk_q("s2_press_rep", prs_r_q, '{});
    chk_q("s2_press_norep", prs_n_q, '{});
    chk_q("s2_release_rep", rel_r_q, '{});

    // Auto-repeat then release
    start();
    run(1'b1, 30);
    chk_q("s3_repeat", prs_r_q, '{6, 16, 19, 22, 25, 28});
    start();
    run(1'b0, 10);
    chk_q("s3_repeat_tail", prs_r_q, '{1, 4});
    chk_q("s3_release", rel_r_q, '{6});

    // Release lands on a scheduled repeat edge (25)
    start();
    run(1'b1, 19);
    run(1'b0, 10);
    chk_q("s4_press", prs_r_q, '{6, 16, 19, 22});
    chk_q("s4_release", rel_r_q, '{25});

    // Reset in the middle of repeating
    start();
    run(1'b1, 20);
    tick(1'b1, 1'b1);
    chk("s5_rst_level", lvl_r, 1'b0);
    chk("s5_rst_press", prs_r, 1'b0);
    chk("s5_rst_release", rel_r, 1'b0);
    start();
    run(1'b1, 8);
    chk_q("s5_requalify", prs_r_q, '{6});
    run(1'b0, 10);

    // Five presses into a downstream counter
    start();
    seg_cnt = 0;
    repeat (5) begin
      run(1'b1, 8);
      run(1'b0, 8);
    end
    chk_int("s6_counter", seg_cnt, 5);
    chk_int("s6_press_count", prs_n_q.size(), 5);
    chk_int("s6_release_count", rel_n_q.size(), 5);

    // Randomised runs with occasional reset, checked cycle by cycle
    for (int k = 0; k < 80; k++) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 25);
      if ($urandom_range(0, 15) == 0) tick(v, 1'b1);
      run(v, len);
    end
    run(1'b0, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
